// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter.
package adder_arb_pkg;

  // Response register occupancy
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } rsp_state_e;

  localparam int unsigned NREQ_MIN = 2;
  localparam int unsigned NREQ_MAX = 16;

  // Ceiling log2, never below 1 so a requester id always has at least one bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < n; i = i * 2) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder.sv
// WIDTH-bit ripple-carry adder, no carry-in; bit 0 of each vector is the LSB.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic [0:WIDTH-1] sum,
  output logic             cout
);

  logic carry;

  // Ripple from bit 0 (LSB) upward
  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [0:NREQ-1] req,
  input  logic [ID_W-1:0] ptr,
  output logic [0:NREQ-1] win,
  output logic [ID_W-1:0] win_idx
);

  logic [31:0]     sel;
  logic [ID_W-1:0] sel_idx;
  logic            found;

  // Scan NREQ slots starting at ptr; the first valid one wins
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    sel     = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sel     = (32'(ptr) + i) % NREQ;
      sel_idx = sel[ID_W-1:0];
      if (!found && req[sel_idx]) begin
        found        = 1'b1;
        win[sel_idx] = 1'b1;
        win_idx      = sel_idx;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin access point to a single shared adder with a one-entry response register.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned  WIDTH = 32,
  parameter int unsigned  NREQ  = 4,
  localparam int unsigned ID_W  = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:NREQ-1]       req_valid,
  output logic [0:NREQ-1]       req_ready,
  input  logic [0:NREQ*WIDTH-1] req_a,
  input  logic [0:NREQ*WIDTH-1] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [0:WIDTH-1]      rsp_sum,
  output logic                  rsp_cout,
  output logic [ID_W-1:0]       rsp_id
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : gen_bad_nreq
    $error("adder_arbiter: NREQ out of range");
  end

  rsp_state_e       state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [0:WIDTH-1] sum_q;
  logic             cout_q;
  logic [ID_W-1:0]  id_q;

  logic [0:NREQ-1]  win;
  logic [ID_W-1:0]  win_idx;
  logic [0:WIDTH-1] op_a, op_b, add_sum;
  logic             add_cout;
  logic             can_accept, accept;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // Operand mux in front of the shared adder, steered by the winner index
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_idx == ID_W'(k)) begin
        op_a = req_a[k*WIDTH +: WIDTH];
        op_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A full register can take a new result only on the edge it drains
  assign can_accept = (state_q == StEmpty) || rsp_ready;
  // Gating with rst_n keeps grants low for the whole reset pulse
  assign req_ready  = (can_accept && rst_n) ? win : '0;
  assign accept     = |req_ready;

  // Response FSM, pointer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= '0;
    end else if (accept) begin
      state_q <= StFull;
      sum_q   <= add_sum;
      cout_q  <= add_cout;
      id_q    <= win_idx;
      ptr_q   <= (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (rsp_ready) begin
      state_q <= StEmpty;
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter at WIDTH=8, NREQ=4.
module tb_adder_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [0:N-1]   req_valid;
  logic [0:N-1]   req_ready;
  logic [0:N*W-1] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [0:W-1]   rsp_sum;
  logic           rsp_cout;
  logic [IDW-1:0] rsp_id;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  adder_arbiter #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data vectors are [0:W-1] with index 0 as LSB
  function automatic logic [0:W-1] to_vec(input logic [W-1:0] x);
    logic [0:W-1] r;
    for (int i = 0; i < W; i++) r[i] = x[i];
    return r;
  endfunction

  function automatic logic [W-1:0] from_vec(input logic [0:W-1] y);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = y[i];
    return r;
  endfunction

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[k*W +: W] = to_vec(a);
    req_b[k*W +: W] = to_vec(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input int id,
                           input logic [W-1:0] s, input logic c);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".id"}, 32'(rsp_id), 32'(id));
    check({tag, ".sum"}, 32'(from_vec(rsp_sum)), 32'(s));
    check({tag, ".cout"}, 32'(rsp_cout), 32'(c));
  endtask

  // Operand table for the all-valid rotation and its hand-computed results
  logic [W-1:0] ta [N] = '{8'h10, 8'h7F, 8'hC0, 8'h33};
  logic [W-1:0] tb [N] = '{8'h05, 8'h01, 8'h50, 8'hCC};
  logic [W-1:0] es [N] = '{8'h15, 8'h80, 8'h10, 8'hFF};
  logic         ec [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int           ord [5] = '{2, 3, 0, 1, 2};

  logic [W-1:0] ra [N];
  logic [W-1:0] rb [N];

  initial begin
    int      exp_id;
    logic [W:0] full;

    // Reset with a request pending: no grant, registers cleared
    rst_n     = 1'b0;
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #2;
    check("reset.ready", 32'(req_ready), 32'h0);
    check_rsp("reset", 1'b0, 0, 8'h00, 1'b0);

    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    // Only req 2: 5 + 7
    set_ops(2, 8'd5, 8'd7);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    check("r2.ready", 32'(req_ready), 32'(4'b0010));
    step();
    check_rsp("r2", 1'b1, 2, 8'd12, 1'b0);

    // ptr is now 3: with reqs 1 and 3 valid, 3 wins (FF+01), then 1 (80+80)
    set_ops(3, 8'hFF, 8'h01);
    set_ops(1, 8'h80, 8'h80);
    req_valid = 4'b0101;
    #1;
    check("ptr3.ready", 32'(req_ready), 32'(4'b0001));
    step();
    check_rsp("ff01", 1'b1, 3, 8'h00, 1'b1);
    check("ptr0.ready", 32'(req_ready), 32'(4'b0100));
    step();
    check_rsp("8080", 1'b1, 1, 8'h00, 1'b1);

    // All valid, rsp_ready held: rotation from ptr=2
    for (int k = 0; k < N; k++) set_ops(k, ta[k], tb[k]);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rot%0d.ready", i), 32'(req_ready), 32'(4'b1000 >> ord[i]));
      step();
      check_rsp($sformatf("rot%0d", i), 1'b1, ord[i], es[ord[i]], ec[ord[i]]);
    end

    // Backpressure: FULL with rsp_ready=0 blocks req 1 and holds the response
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    set_ops(1, 8'h22, 8'h44);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d.ready", i), 32'(req_ready), 32'h0);
      check_rsp($sformatf("bp%0d", i), 1'b1, 2, 8'h10, 1'b1);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("drainfill.ready", 32'(req_ready), 32'(4'b0100));
    step();
    check_rsp("drainfill", 1'b1, 1, 8'h66, 1'b0);

    // Reset mid-stream while FULL: response dropped at once, ptr back to 0
    rsp_ready = 1'b0;
    req_valid = 4'b1001;
    #1;
    rst_n = 1'b0;
    #1;
    check_rsp("midrst", 1'b0, 0, 8'h00, 1'b0);
    check("midrst.ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("postrst.ready", 32'(req_ready), 32'(4'b1000));
    step();
    check_rsp("postrst0", 1'b1, 0, 8'h15, 1'b0);
    check("postrst.block", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    #1;
    check("postrst3.ready", 32'(req_ready), 32'(4'b0001));
    step();
    check_rsp("postrst3", 1'b1, 3, 8'hFF, 1'b0);

    // No requests, consumer ready: register empties, stale data held
    req_valid = 4'b0000;
    step();
    check_rsp("drain", 1'b0, 3, 8'hFF, 1'b0);
    check("drain.ready", 32'(req_ready), 32'h0);

    // Random operands, all requesters valid: strict rotation, each waits < NREQ accepts
    for (int k = 0; k < N; k++) begin
      ra[k] = W'($urandom);
      rb[k] = W'($urandom);
      set_ops(k, ra[k], rb[k]);
    end
    req_valid = 4'b1111;
    exp_id    = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      check($sformatf("rnd%0d.ready", i), 32'(req_ready), 32'(4'b1000 >> exp_id));
      full = {1'b0, ra[exp_id]} + {1'b0, rb[exp_id]};
      step();
      check_rsp($sformatf("rnd%0d", i), 1'b1, exp_id, full[W-1:0], full[W]);
      ra[exp_id] = W'($urandom);
      rb[exp_id] = W'($urandom);
      set_ops(exp_id, ra[exp_id], rb[exp_id]);
      exp_id = (exp_id + 1) % N;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
